// File: rtl/multicycle_ctrl_if.sv
// Memory-port bundle between the multicycle controller and the shared
// instruction/data memory.
//   mem_req  : controller requests a memory access this cycle
//   mem_we   : access is a write (store)
//   mem_iord : address select, 0 = PC (instruction fetch), 1 = ALU result (data)
//   mem_ack  : memory completes the current request this cycle
// Modports: master = controller side, slave = memory side.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_iord;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_iord,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_iord,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multicycle DLX datapath. It walks each instruction
// through FETCH / DECODE / EXEC / MEM / WB (or MULW for multiplies), emits
// the per-cycle datapath enables and counts retired instructions.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   mem                 : memory port (mem_req/mem_we/mem_iord out, mem_ack in)
//   dec_*               : decoded instruction flags from the current IR
//   br_taken            : branch condition, meaningful in EXEC
//   ir_wr, pc_wr        : IR / PC load enables
//   pc_src              : 00 PC+4, 01 branch target, 10 jump target, 11 register
//   reg_wr              : register-file write enable
//   mult_busy           : multiplier occupied
//   state               : current FSM state (debug)
//   retired             : retired-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_if.master    mem,
    input  logic                 dec_memRd,
    input  logic                 dec_memWr,
    input  logic                 dec_regWr,
    input  logic                 dec_branch,
    input  logic                 br_taken,
    input  logic                 dec_jump,
    input  logic                 dec_jr,
    input  logic                 dec_link,
    input  logic                 dec_mult,
    output logic                 ir_wr,
    output logic                 pc_wr,
    output logic [1:0]           pc_src,
    output logic                 reg_wr,
    output logic                 mult_busy,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_MULW   = 3'd5;

    // Counter holds the remaining MULW cycles after the current one.
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);

    logic [2:0]       state_reg, state_next;
    logic [7:0]       mult_cnt_reg, mult_cnt_next;
    logic [CNT_W-1:0] retired_reg;
    logic             retire_evt;

    // State register and multiply counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            mult_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            mult_cnt_reg <= mult_cnt_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next    = state_reg;
        mult_cnt_next = mult_cnt_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem.mem_ack) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (dec_mult) begin
                    state_next    = S_MULW;
                    mult_cnt_next = MULT_LOAD;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_branch)                   state_next = S_FETCH;
                else if (dec_jump)                state_next = dec_link ? S_WB : S_FETCH;
                else if (dec_memRd || dec_memWr)  state_next = S_MEM;
                else if (dec_regWr)               state_next = S_WB;
                else                              state_next = S_FETCH;
            end
            S_MEM: begin
                // Loads need a write-back cycle; stores retire on the ack.
                if (mem.mem_ack) state_next = dec_memRd ? S_WB : S_FETCH;
            end
            S_WB: begin
                state_next = S_FETCH;
            end
            S_MULW: begin
                if (mult_cnt_reg == 8'd0) state_next = S_WB;
                else                      mult_cnt_next = mult_cnt_reg - 8'd1;
            end
            default: begin
                // Unused encodings recover to FETCH.
                state_next = S_FETCH;
            end
        endcase
    end

    // An instruction retires when it hands control back to FETCH.
    assign retire_evt = (state_next == S_FETCH) &&
                        ((state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_reg <= '0;
        else if (retire_evt) retired_reg <= retired_reg + CNT_W'(1);
    end

    // Output logic. Everything is forced low while reset is held so that an
    // outstanding memory request is withdrawn in the same cycle.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_iord = 1'b0;
        ir_wr        = 1'b0;
        pc_wr        = 1'b0;
        pc_src       = 2'b00;
        reg_wr       = 1'b0;
        mult_busy    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                end
            end
            S_EXEC: begin
                if (dec_branch) begin
                    pc_wr  = br_taken;
                    pc_src = 2'b01;
                end else if (dec_jump) begin
                    pc_wr  = 1'b1;
                    pc_src = dec_jr ? 2'b11 : 2'b10;
                end
            end
            S_MEM: begin
                mem.mem_req  = 1'b1;
                mem.mem_iord = 1'b1;
                mem.mem_we   = dec_memWr;
            end
            S_WB: begin
                reg_wr = 1'b1;
            end
            S_MULW: begin
                mult_busy = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            mem.mem_req  = 1'b0;
            mem.mem_we   = 1'b0;
            mem.mem_iord = 1'b0;
            ir_wr        = 1'b0;
            pc_wr        = 1'b0;
            pc_src       = 2'b00;
            reg_wr       = 1'b0;
            mult_busy    = 1'b0;
        end
    end

    assign state   = state_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions from the test plan, then a
// randomized instruction stream with random memory wait states. For every
// instruction the bench expands the instruction's architectural schedule into
// an expected per-cycle trace and compares state and outputs each cycle.
module tb_multicycle_ctrl;

    localparam int MC    = 4;
    localparam int CNT_W = 32;

    // Instruction kinds.
    localparam int K_ALU  = 0;
    localparam int K_LW   = 1;
    localparam int K_SW   = 2;
    localparam int K_BEQZ = 3;
    localparam int K_J    = 4;
    localparam int K_JAL  = 5;
    localparam int K_JR   = 6;
    localparam int K_JALR = 7;
    localparam int K_MULT = 8;
    localparam int K_NOP  = 9;

    logic clk = 1'b0;
    logic rst;
    logic dec_memRd, dec_memWr, dec_regWr, dec_branch, br_taken;
    logic dec_jump, dec_jr, dec_link, dec_mult;
    logic ir_wr, pc_wr, reg_wr, mult_busy;
    logic [1:0] pc_src;
    logic [2:0] state;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MULT_CYCLES(MC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mem(bus),
        .dec_memRd(dec_memRd), .dec_memWr(dec_memWr), .dec_regWr(dec_regWr),
        .dec_branch(dec_branch), .br_taken(br_taken), .dec_jump(dec_jump),
        .dec_jr(dec_jr), .dec_link(dec_link), .dec_mult(dec_mult),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr),
        .mult_busy(mult_busy), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // One expected cycle: state, packed outputs and the mem_ack to drive.
    typedef struct packed {
        logic [2:0] st;
        logic [8:0] outs;   // {req, we, iord, ir_wr, pc_wr, pc_src[1:0], reg_wr, mult_busy}
        logic       ack;
    } cyc_t;

    cyc_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    int exp_retired = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] o(input bit req, input bit we, input bit iord, input bit irw,
                                     input bit pcw, input logic [1:0] src, input bit rw, input bit mb);
        return {req, we, iord, irw, pcw, src, rw, mb};
    endfunction

    function automatic logic [8:0] dut_outs();
        return {bus.mem_req, bus.mem_we, bus.mem_iord, ir_wr, pc_wr, pc_src, reg_wr, mult_busy};
    endfunction

    task automatic push(input logic [2:0] st, input logic [8:0] outs, input logic ack);
        cyc_t c;
        c.st = st; c.outs = outs; c.ack = ack;
        q.push_back(c);
    endtask

    // Stray acks outside FETCH/MEM must be ignored, so inject them randomly.
    function automatic logic noise();
        return logic'($urandom_range(0, 1));
    endfunction

    // Run one instruction. abort_at >= 0 asserts reset during that cycle.
    task automatic run_instr(input int kind, input int wf, input int wm, input bit taken,
                             input int abort_at);
        bit ld, stw, rw, br, jmp, jr, lk, mul;
        ld  = (kind == K_LW);
        stw = (kind == K_SW);
        rw  = (kind == K_ALU) || ld || (kind == K_JAL) || (kind == K_JALR) || (kind == K_MULT);
        br  = (kind == K_BEQZ);
        jmp = (kind == K_J) || (kind == K_JAL) || (kind == K_JR) || (kind == K_JALR);
        jr  = (kind == K_JR) || (kind == K_JALR);
        lk  = (kind == K_JAL) || (kind == K_JALR);
        mul = (kind == K_MULT);

        q.delete();
        for (int i = 0; i < wf; i++) push(3'd0, o(1,0,0,0,0,2'b00,0,0), 1'b0);
        push(3'd0, o(1,0,0,1,1,2'b00,0,0), 1'b1);
        push(3'd1, o(0,0,0,0,0,2'b00,0,0), noise());
        if (mul) begin
            for (int i = 0; i < MC; i++) push(3'd5, o(0,0,0,0,0,2'b00,0,1), noise());
            push(3'd4, o(0,0,0,0,0,2'b00,1,0), noise());
        end else if (br) begin
            push(3'd2, o(0,0,0,0,taken,2'b01,0,0), noise());
        end else if (jmp) begin
            push(3'd2, o(0,0,0,0,1,jr ? 2'b11 : 2'b10,0,0), noise());
            if (lk) push(3'd4, o(0,0,0,0,0,2'b00,1,0), noise());
        end else if (ld || stw) begin
            push(3'd2, o(0,0,0,0,0,2'b00,0,0), noise());
            for (int i = 0; i < wm; i++) push(3'd3, o(1,stw,1,0,0,2'b00,0,0), 1'b0);
            push(3'd3, o(1,stw,1,0,0,2'b00,0,0), 1'b1);
            if (ld) push(3'd4, o(0,0,0,0,0,2'b00,1,0), noise());
        end else begin
            push(3'd2, o(0,0,0,0,0,2'b00,0,0), noise());
            if (rw) push(3'd4, o(0,0,0,0,0,2'b00,1,0), noise());
        end

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                dec_memRd = ld;  dec_memWr = stw; dec_regWr = rw;
                dec_branch = br; dec_jump = jmp;  dec_jr = jr;
                dec_link = lk;   dec_mult = mul;
                br_taken = br ? taken : logic'($urandom_range(0, 1));
            end
            bus.mem_ack = q[i].ack;
            #1;
            if (i == 0) check("retired", 64'(retired), 64'(exp_retired));
            check("state", 64'(state), 64'(q[i].st));
            check("outs", 64'(dut_outs()), 64'(q[i].outs));
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_mem_req", 64'(bus.mem_req), 64'd0);
                check("rst_state", 64'(state), 64'd0);
                check("rst_retired", 64'(retired), 64'd0);
                check("rst_outs", 64'(dut_outs()), 64'd0);
                @(posedge clk);
                #1;
                check("rst_hold_outs", 64'(dut_outs()), 64'd0);
                check("rst_hold_state", 64'(state), 64'd0);
                @(negedge clk);
                bus.mem_ack = 1'b0;
                rst = 1'b0;
                exp_retired = 0;
                return;
            end
        end
        exp_retired++;
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        {dec_memRd, dec_memWr, dec_regWr, dec_branch, br_taken} = '0;
        {dec_jump, dec_jr, dec_link, dec_mult} = '0;
        @(negedge clk);
        #1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_outs", 64'(dut_outs()), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases from the test plan.
        run_instr(K_ALU,  2, 0, 1'b0, -1);
        run_instr(K_LW,   0, 0, 1'b0, -1);
        run_instr(K_SW,   0, 3, 1'b0, -1);
        run_instr(K_BEQZ, 0, 0, 1'b1, -1);
        run_instr(K_BEQZ, 0, 0, 1'b0, -1);
        run_instr(K_JALR, 0, 0, 1'b0, -1);
        run_instr(K_J,    0, 0, 1'b0, -1);
        run_instr(K_JAL,  1, 0, 1'b0, -1);
        run_instr(K_JR,   0, 0, 1'b0, -1);
        run_instr(K_NOP,  0, 0, 1'b0, -1);
        run_instr(K_MULT, 0, 0, 1'b0, -1);
        // Store stuck waiting in MEM, reset hits during the wait.
        run_instr(K_SW,   0, 5, 1'b0, 5);

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            run_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), -1);
        end

        // Final retire count after the last instruction returns to FETCH.
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check("final_retired", 64'(retired), 64'(exp_retired));
        check("final_state", 64'(state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencing FSM for the multicycle variant of the DLX datapath: drives IR/PC writes, the shared instruction/data memory port, register-file write enable and the multiply wait.
- Consumes the per-instruction decoded flags produced by the combinational decoder from the current IR; emits per-cycle enables only.
- Also counts retired instructions for the testbench and performance checks.

Parameters:
- MULT_CYCLES, 4, number of cycles a mult/multu occupies the multiplier (legal range 1..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_ack  in  1  memory port completes the current request this cycle.
- dec_memRd  in  1  decoded load.
- dec_memWr  in  1  decoded store.
- dec_regWr  in  1  decoded register write.
- dec_branch  in  1  decoded beqz/bnez.
- br_taken  in  1  branch condition from ALU zero test; valid in EXEC.
- dec_jump  in  1  decoded j/jal/jr/jalr.
- dec_jr  in  1  jump target comes from a register.
- dec_link  in  1  jump writes the link register.
- dec_mult  in  1  decoded mult/multu.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store).
- mem_iord  out  1  address select: 0 = PC (instruction), 1 = ALU result (data).
- ir_wr  out  1  IR load enable.
- pc_wr  out  1  PC load enable.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = register.
- reg_wr  out  1  register-file write enable.
- mult_busy  out  1  multiplier occupied.
- state  out  3  current FSM state, for debug.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, MULW = 5. Encodings 6 and 7 recover to FETCH on the next edge.
- Reset: state = FETCH, mult counter = 0, retired = 0. While rst is high, every output except state and retired is forced to 0, including mem_req.
- Outputs are combinational from the state and inputs; all unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: mem_req = 1, mem_iord = 0, mem_we = 0.
  - Holds until mem_ack. In the ack cycle: ir_wr = 1, pc_wr = 1, pc_src = 00; next state is DECODE.
  - Wait states are unbounded.
- DECODE: single cycle. Next state is MULW if dec_mult, otherwise EXEC. On entry to MULW the counter loads MULT_CYCLES-1.
- EXEC: single cycle. Decisions in priority order:
  - dec_branch: pc_wr = br_taken, pc_src = 01; next state FETCH.
  - dec_jump: pc_wr = 1, pc_src = 11 if dec_jr else 10; next state WB if dec_link, else FETCH.
  - dec_memRd or dec_memWr: next state MEM.
  - dec_regWr: next state WB.
  - Otherwise (nop): next state FETCH.
- MEM:
  - Outputs: mem_req = 1, mem_iord = 1, mem_we = dec_memWr.
  - Holds until mem_ack. On ack: load goes to WB, store goes to FETCH.
  - mem_we and mem_iord are stable for the whole request.
- WB: reg_wr = 1 for exactly one cycle; next state FETCH.
- MULW:
  - mult_busy = 1.
  - When the counter is 0, next state is WB; otherwise the counter decrements.
  - Total MULW dwell is MULT_CYCLES cycles.
- retired: increments by 1 on every transition into FETCH from EXEC, MEM or WB. Wraps modulo 2^CNT_W.
- mem_ack outside FETCH and MEM is ignored.
- dec_* inputs are sampled only in DECODE through WB; IR changes only on ir_wr, so they are stable across an instruction.
- rst asserted mid-instruction (any state, including an outstanding memory request): mem_req drops immediately, the FSM is in FETCH, and the partially executed instruction does not count.
- Latencies with zero-wait memory:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch / j: 3 cycles.
  - jal: 4 cycles.
  - mult: 3 + MULT_CYCLES cycles.

Test Plan:
- add, FETCH ack delayed 2 cycles: states 0,0,0,1,2,4,0; ir_wr and pc_wr high only in the third cycle; reg_wr high exactly 1 cycle; retired = 1.
- lw, zero-wait memory: MEM cycle shows mem_req = 1, mem_iord = 1, mem_we = 0; then WB with reg_wr = 1; 5 cycles total; retired increments.
- sw, MEM ack delayed 3 cycles: mem_we = 1 held 4 cycles with mem_iord = 1; no reg_wr; returns to FETCH.
- beqz taken vs not taken:
  - Taken: EXEC shows pc_wr = 1, pc_src = 01.
  - Not taken: pc_wr = 0.
  - Both return to FETCH; 3 cycles each.
- jalr: EXEC pc_wr = 1, pc_src = 11, then WB reg_wr = 1; j: pc_src = 10 and no WB.
- mult with MULT_CYCLES = 4: mult_busy high 4 cycles, then WB; then reset asserted during a MEM wait: mem_req = 0 in the same cycle, state = 0, retired = 0.
